intersection_phase_scheduler: RTL and testbench

//  Top-level phase scheduler for the traffic controller. Sequences the NS/EW signal heads

---
 rtl/intersection_phase_scheduler.sv | 257 +++++++++++++++++++++++++
 tb/tb_intersection_phase_scheduler.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/intersection_phase_scheduler.sv
// -----------------------------------------------------------------------------
// intersection_phase_scheduler
//
// Top-level phase scheduler for the traffic controller. Walks the NS/EW signal
// heads through AR_NS -> NS_G -> NS_Y -> AR_EW -> EW_G -> EW_Y -> AR_NS.
// In timed mode each green lasts GREEN_MAX cycles. In sensor mode a green
// lasts at least GREEN_MIN cycles and then yields as soon as the opposing
// approach has a car pending; with nothing pending it holds indefinitely.
//
// Optional feature macro: PED_WALK_EN
//   When defined, a sticky pedestrian request inserts a WALK phase (both heads
//   red, walk=1, WALK_T cycles) between EW_Y and AR_NS.
//
// Ports
//   CLOCK              in   system clock, rising edge
//   RESET              in   asynchronous active-low reset
//   mode_sel           in   1 = sensor mode, 0 = timed mode
//   ns_car / ew_car    in   car waiting on the NS / EW approach (level)
//   ns_light/ew_light  out  {R,Y,G} for each head, registered
//   enable_sensor_mode out  mode_sel captured on each entry into AR_NS
//   SET_srl            out  1-cycle pulse on green entry while in sensor mode
//   counter3_RST       out  1-cycle pulse in the first cycle of every phase
//   ped_req / walk     in/out  pedestrian request / walk indication
//                           (PED_WALK_EN only)
// -----------------------------------------------------------------------------
module intersection_phase_scheduler #(
  parameter int CNT_W     = 4,
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 10,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 2
`ifdef PED_WALK_EN
  , parameter int WALK_T  = 5
`endif
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       mode_sel,
  input  logic       ns_car,
  input  logic       ew_car,
`ifdef PED_WALK_EN
  input  logic       ped_req,
  output logic       walk,
`endif
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       enable_sensor_mode,
  output logic       SET_srl,
  output logic       counter3_RST
);

  typedef enum logic [2:0] {
    ST_AR_NS = 3'd0,
    ST_NS_G  = 3'd1,
    ST_NS_Y  = 3'd2,
    ST_AR_EW = 3'd3,
    ST_EW_G  = 3'd4,
    ST_EW_Y  = 3'd5
`ifdef PED_WALK_EN
    , ST_WALK = 3'd6
`endif
  } state_t;

  // Last timer value of each phase: a phase of length L exits when timer == L-1.
  localparam logic [CNT_W-1:0] GMIN_LAST   = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_LAST   = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_T - 1);
`ifdef PED_WALK_EN
  localparam logic [CNT_W-1:0] WALK_LAST   = CNT_W'(WALK_T - 1);
`endif
  localparam logic [CNT_W-1:0] TMR_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] TMR_ONE     = CNT_W'(1);

  localparam logic [2:0] LT_RED    = 3'b100;
  localparam logic [2:0] LT_YELLOW = 3'b010;
  localparam logic [2:0] LT_GREEN  = 3'b001;

  // {ns_light, ew_light} for a given phase; every non-green/yellow phase is all-red.
  function automatic logic [5:0] decode_lights(input state_t st);
    logic [5:0] lights;
    case (st)
      ST_NS_G: lights = {LT_GREEN,  LT_RED};
      ST_NS_Y: lights = {LT_YELLOW, LT_RED};
      ST_EW_G: lights = {LT_RED,    LT_GREEN};
      ST_EW_Y: lights = {LT_RED,    LT_YELLOW};
      default: lights = {LT_RED,    LT_RED};
    endcase
    return lights;
  endfunction

  state_t           state_r;
  state_t           state_nxt_s;
  state_t           target_s;
  logic [CNT_W-1:0] timer_r;
  logic [CNT_W-1:0] timer_nxt_s;
  logic             phase_done_s;
  logic             hold_s;
  logic             ns_req_r;
  logic             ew_req_r;
  logic             ns_pend_s;
  logic             ew_pend_s;
  logic             ns_green_entry_s;
  logic             ew_green_entry_s;
  logic [5:0]       lights_nxt_s;
`ifdef PED_WALK_EN
  logic             ped_req_r;
  logic             ped_pend_s;
  logic             walk_entry_s;
`endif

  // A request seen this cycle counts immediately, so a car arriving after the
  // minimum green has elapsed ends the green on the very next edge.
  assign ns_pend_s = ns_req_r | ns_car;
  assign ew_pend_s = ew_req_r | ew_car;
`ifdef PED_WALK_EN
  assign ped_pend_s = ped_req_r | ped_req;
`endif

  // Next-state and timer logic: decide whether the current phase ends this cycle.
  always_comb begin
    target_s     = state_r;
    phase_done_s = 1'b0;
    hold_s       = 1'b0;
    case (state_r)
      ST_AR_NS: begin
        target_s     = ST_NS_G;
        phase_done_s = (timer_r == ALLRED_LAST);
      end
      ST_NS_G: begin
        target_s = ST_NS_Y;
        if (enable_sensor_mode) begin
          phase_done_s = (timer_r >= GMIN_LAST) && ew_pend_s;
          hold_s       = (timer_r >= GMIN_LAST);
        end else begin
          phase_done_s = (timer_r == GMAX_LAST);
        end
      end
      ST_NS_Y: begin
        target_s     = ST_AR_EW;
        phase_done_s = (timer_r == YELLOW_LAST);
      end
      ST_AR_EW: begin
        target_s     = ST_EW_G;
        phase_done_s = (timer_r == ALLRED_LAST);
      end
      ST_EW_G: begin
        target_s = ST_EW_Y;
        if (enable_sensor_mode) begin
          phase_done_s = (timer_r >= GMIN_LAST) && ns_pend_s;
          hold_s       = (timer_r >= GMIN_LAST);
        end else begin
          phase_done_s = (timer_r == GMAX_LAST);
        end
      end
      ST_EW_Y: begin
        phase_done_s = (timer_r == YELLOW_LAST);
`ifdef PED_WALK_EN
        if (ped_pend_s) begin
          target_s = ST_WALK;
        end else begin
          target_s = ST_AR_NS;
        end
`else
        target_s = ST_AR_NS;
`endif
      end
`ifdef PED_WALK_EN
      ST_WALK: begin
        target_s     = ST_AR_NS;
        phase_done_s = (timer_r == WALK_LAST);
      end
`endif
      default: begin
        // Unreachable encodings recover through an all-red restart.
        target_s     = ST_AR_NS;
        phase_done_s = 1'b1;
      end
    endcase

    if (phase_done_s) begin
      state_nxt_s = target_s;
      timer_nxt_s = TMR_ZERO;
    end else if (hold_s) begin
      // Sensor-mode green with nobody waiting: timer parks at GREEN_MIN-1.
      state_nxt_s = state_r;
      timer_nxt_s = timer_r;
    end else begin
      state_nxt_s = state_r;
      timer_nxt_s = timer_r + TMR_ONE;
    end
  end

  assign ns_green_entry_s = phase_done_s && (target_s == ST_NS_G);
  assign ew_green_entry_s = phase_done_s && (target_s == ST_EW_G);
`ifdef PED_WALK_EN
  assign walk_entry_s     = phase_done_s && (target_s == ST_WALK);
`endif
  assign lights_nxt_s     = decode_lights(state_nxt_s);

  // State, timer, request flags and all registered outputs.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_r            <= ST_AR_NS;
      timer_r            <= TMR_ZERO;
      ns_req_r           <= 1'b0;
      ew_req_r           <= 1'b0;
      enable_sensor_mode <= 1'b0;
      SET_srl            <= 1'b0;
      counter3_RST       <= 1'b0;
      ns_light           <= LT_RED;
      ew_light           <= LT_RED;
`ifdef PED_WALK_EN
      ped_req_r          <= 1'b0;
      walk               <= 1'b0;
`endif
    end else begin
      state_r      <= state_nxt_s;
      timer_r      <= timer_nxt_s;
      counter3_RST <= phase_done_s;
      // enable_sensor_mode only changes on AR_NS entry, never together with a
      // green entry, so the current value is the one the new green will see.
      SET_srl      <= (ns_green_entry_s || ew_green_entry_s) && enable_sensor_mode;
      ns_light     <= lights_nxt_s[5:3];
      ew_light     <= lights_nxt_s[2:0];

      if (phase_done_s && (target_s == ST_AR_NS)) begin
        enable_sensor_mode <= mode_sel;
      end else begin
        enable_sensor_mode <= enable_sensor_mode;
      end

      // A request arriving in the same cycle as the clear survives it.
      if (ns_green_entry_s) begin
        ns_req_r <= ns_car;
      end else begin
        ns_req_r <= ns_pend_s;
      end

      if (ew_green_entry_s) begin
        ew_req_r <= ew_car;
      end else begin
        ew_req_r <= ew_pend_s;
      end

`ifdef PED_WALK_EN
      if (walk_entry_s) begin
        ped_req_r <= ped_req;
      end else begin
        ped_req_r <= ped_pend_s;
      end
      walk <= (state_nxt_s == ST_WALK);
`endif
    end
  end

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// -----------------------------------------------------------------------------
// tb_intersection_phase_scheduler
//
// Directed bench for intersection_phase_scheduler. One linear sequence walks
// through timed mode, a mid-green mode change, sensor-mode holding and early
// exit, an asynchronous reset in yellow and (with PED_WALK_EN) a walk phase.
// Outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_intersection_phase_scheduler;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  // pulse selectors for expect_phase
  localparam int P_NONE = 0;
  localparam int P_EW   = 1;
  localparam int P_NS   = 2;
  localparam int P_MODE = 3;
  localparam int P_PED  = 4;
`ifdef PED_WALK_EN
  localparam int PED_SEL = P_PED;
`else
  localparam int PED_SEL = P_NONE;
`endif

  logic       CLOCK;
  logic       RESET;
  logic       mode_sel;
  logic       ns_car;
  logic       ew_car;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       enable_sensor_mode;
  logic       SET_srl;
  logic       counter3_RST;
`ifdef PED_WALK_EN
  logic       ped_req;
  logic       walk;
`endif

  int n_tests;
  int n_fail;

  intersection_phase_scheduler dut (
`ifdef PED_WALK_EN
    .ped_req            (ped_req),
    .walk               (walk),
`endif
    .CLOCK              (CLOCK),
    .RESET              (RESET),
    .mode_sel           (mode_sel),
    .ns_car             (ns_car),
    .ew_car             (ew_car),
    .ns_light           (ns_light),
    .ew_light           (ew_light),
    .enable_sensor_mode (enable_sensor_mode),
    .SET_srl            (SET_srl),
    .counter3_RST       (counter3_RST)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic chk(input logic [2:0] obs, input logic [2:0] exp, input string tag);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  // Called in the first cycle of a phase; checks every cycle of it and leaves
  // the bench in the first cycle of the following phase.
  task automatic expect_phase(input logic [2:0] ns, input logic [2:0] ew, input int len,
                              input logic en, input logic set_first,
                              input int pulse_at, input int pulse_sel, input string tag);
    for (int i = 0; i < len; i++) begin
      chk(ns_light, ns, $sformatf("%s.ns[%0d]", tag, i));
      chk(ew_light, ew, $sformatf("%s.ew[%0d]", tag, i));
      chk({2'b00, counter3_RST}, {2'b00, (i == 0)}, $sformatf("%s.c3rst[%0d]", tag, i));
      chk({2'b00, SET_srl}, {2'b00, (set_first && i == 0)}, $sformatf("%s.set[%0d]", tag, i));
      chk({2'b00, enable_sensor_mode}, {2'b00, en}, $sformatf("%s.en[%0d]", tag, i));
`ifdef PED_WALK_EN
      chk({2'b00, walk}, 3'b000, $sformatf("%s.walk[%0d]", tag, i));
`endif
      if (i == pulse_at) begin
        case (pulse_sel)
          P_EW:    ew_car = 1'b1;
          P_NS:    ns_car = 1'b1;
          P_MODE:  mode_sel = 1'b1;
`ifdef PED_WALK_EN
          P_PED:   ped_req = 1'b1;
`endif
          default: ;
        endcase
      end else begin
        ew_car = 1'b0;
        ns_car = 1'b0;
`ifdef PED_WALK_EN
        ped_req = 1'b0;
`endif
      end
      tick();
    end
    ew_car = 1'b0;
    ns_car = 1'b0;
`ifdef PED_WALK_EN
    ped_req = 1'b0;
`endif
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    RESET    = 1'b0;
    mode_sel = 1'b0;
    ns_car   = 1'b0;
    ew_car   = 1'b0;
`ifdef PED_WALK_EN
    ped_req  = 1'b0;
`endif

    // ---- reset state, then release (timed mode) ----
    repeat (3) @(negedge CLOCK);
    #1;
    chk(ns_light, RED, "rst.ns");
    chk(ew_light, RED, "rst.ew");
    chk({2'b00, enable_sensor_mode}, 3'b000, "rst.en");
    chk({2'b00, SET_srl}, 3'b000, "rst.set");
    chk({2'b00, counter3_RST}, 3'b000, "rst.c3rst");
    RESET = 1'b1;
    tick();
    chk(ns_light, RED, "ar0.ns");
    chk(ew_light, RED, "ar0.ew");
    chk({2'b00, counter3_RST}, 3'b000, "ar0.c3rst");
    tick();

    // ---- timed cycle; mode_sel rises in NS_G cycle 3 but this cycle stays timed ----
    expect_phase(GRN, RED, 10, 1'b0, 1'b0, 3, P_MODE, "t_nsg");
    expect_phase(YEL, RED, 3,  1'b0, 1'b0, -1, P_NONE, "t_nsy");
    expect_phase(RED, RED, 2,  1'b0, 1'b0, -1, P_NONE, "t_arew");
    expect_phase(RED, GRN, 10, 1'b0, 1'b0, 2, PED_SEL, "t_ewg");
    expect_phase(RED, YEL, 3,  1'b0, 1'b0, -1, P_NONE, "t_ewy");
`ifdef PED_WALK_EN
    for (int i = 0; i < 5; i++) begin
      chk(ns_light, RED, $sformatf("walk.ns[%0d]", i));
      chk(ew_light, RED, $sformatf("walk.ew[%0d]", i));
      chk({2'b00, walk}, 3'b001, $sformatf("walk.walk[%0d]", i));
      chk({2'b00, counter3_RST}, {2'b00, (i == 0)}, $sformatf("walk.c3rst[%0d]", i));
      tick();
    end
`endif

    // ---- next AR_NS entry picks up sensor mode ----
    expect_phase(RED, RED, 2, 1'b1, 1'b0, -1, P_NONE, "s_arns");
    // no cars: NS green holds; ew_car in cycle 55 ends it on the next edge
    expect_phase(GRN, RED, 56, 1'b1, 1'b1, 55, P_EW, "s_nsg_hold");
    expect_phase(YEL, RED, 3,  1'b1, 1'b0, -1, P_NONE, "s_nsy");
    expect_phase(RED, RED, 2,  1'b1, 1'b0, -1, P_NONE, "s_arew");
    expect_phase(RED, GRN, 8,  1'b1, 1'b1, 7, P_NS, "s_ewg");
    expect_phase(RED, YEL, 3,  1'b1, 1'b0, -1, P_NONE, "s_ewy");
    // no pedestrian request this time: straight back to AR_NS
    expect_phase(RED, RED, 2,  1'b1, 1'b0, -1, P_NONE, "s_arns2");
    // ew_car in NS_G cycle 1: green is exactly GREEN_MIN = 4 cycles
    expect_phase(GRN, RED, 4,  1'b1, 1'b1, 1, P_EW, "s_nsg_min");

    // ---- async reset in NS_Y cycle 1 ----
    chk(ns_light, YEL, "ar_rst.nsy0");
    chk({2'b00, counter3_RST}, 3'b001, "ar_rst.c3rst");
    tick();
    chk(ns_light, YEL, "ar_rst.nsy1");
    #2;
    RESET = 1'b0;
    #1;
    chk(ns_light, RED, "ar_rst.ns");
    chk(ew_light, RED, "ar_rst.ew");
    chk({2'b00, enable_sensor_mode}, 3'b000, "ar_rst.en");
    @(negedge CLOCK);
    RESET = 1'b1;
    tick();
    chk(ns_light, RED, "rel.ns");
    chk(ew_light, RED, "rel.ew");
    chk({2'b00, counter3_RST}, 3'b000, "rel.c3rst");
    tick();
    // enable cleared by reset, so this green is timed even with mode_sel=1
    expect_phase(GRN, RED, 10, 1'b0, 1'b0, -1, P_NONE, "r_nsg");
    expect_phase(YEL, RED, 3,  1'b0, 1'b0, -1, P_NONE, "r_nsy");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
